// File: rtl/sd_controller_data_receiver.sv
// SD DAT receive path: start-bit detect, 512-byte block assembly into 32-bit words, CRC16/end-bit check.
// Optional build macro SD_RX_CRC_CHECK_EN enables the per-line CRC16 generators and compare.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no transfer; waits for start
// WAIT_BUF   | holds the SD clock until the buffer write half is free
// WAIT_START | counts strobes looking for the start bit, times out
// DATA       | shifts data symbols, writes one buffer word per 32 bits
// CRC        | consumes 16 CRC symbols per active line
// END        | samples the end bit on all active lines
// COMMIT     | writes the property word and hands the half to the reader

module sd_controller_data_receiver #(
   parameter int ADDR_WIDTH = 7,
   parameter int PROP_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  sd_clk_en,
   input  logic [3:0]            sd_dat,
   input  logic                  bus_width_4,
   input  logic                  start,
   input  logic [15:0]           block_count,
   input  logic [23:0]           timeout_cycles,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic                  crc_err,
   output logic                  clk_hold,
   output logic [ADDR_WIDTH-1:0] buf_waddr,
   output logic [31:0]           buf_wdata,
   output logic                  buf_we,
   output logic [PROP_WIDTH-1:0] buf_wprop,
   output logic                  buf_wupdate,
   input  logic                  buf_wvalid
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_BUF, S_WAIT_START, S_DATA, S_CRC, S_END, S_COMMIT
   } state_t;

   state_t state, state_next;

   logic                  mode4;
   logic [15:0]           blocks_left;
   logic [15:0]           blk_idx;
   logic [23:0]           tmo_cnt;
   logic [4:0]            sym_cnt;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]           sr;
   logic [3:0]            crc_cnt;
   logic                  end_err;

   logic                  start_bit;
   logic                  end_bad;
   logic                  crc_bad;
   logic                  last_word;
   logic                  last_block;
   logic [4:0]            sym_reload;
   logic [31:0]           sr_next;
   logic [PROP_WIDTH-1:0] prop;

   function automatic logic [31:0] swap_bytes(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

`ifdef SD_RX_CRC_CHECK_EN
   logic [15:0] crc_gen [4];
   logic [15:0] crc_rx  [4];

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
      logic fb;
      fb = c[15] ^ d;
      return fb ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
   endfunction

   always_comb begin
      crc_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((mode4 || i == 0) && crc_gen[i] != crc_rx[i]) crc_bad = 1'b1;
      end
   end
`else
   assign crc_bad = 1'b0;
`endif

   // Stream is MSB-first per byte; the byte swap yields little-endian word packing.
   assign start_bit  = mode4 ? (sd_dat == 4'h0) : !sd_dat[0];
   assign end_bad    = mode4 ? (sd_dat != 4'hF) : !sd_dat[0];
   assign sr_next    = mode4 ? {sr[27:0], sd_dat} : {sr[30:0], sd_dat[0]};
   assign sym_reload = mode4 ? 5'd7 : 5'd31;
   assign last_word  = &word_idx;
   assign last_block = (blocks_left == 16'd1);

   always_comb begin
      prop        = '0;
      prop[15:0]  = blk_idx;
      prop[16]    = crc_bad;
      prop[17]    = end_err;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      clk_hold   = 1'b0;
      case (state)
         S_IDLE:
            if (start && !busy && block_count != 16'd0) state_next = S_WAIT_BUF;
         S_WAIT_BUF: begin
            clk_hold = 1'b1;
            if (buf_wvalid) state_next = S_WAIT_START;
         end
         S_WAIT_START:
            if (sd_clk_en) begin
               if (start_bit)                state_next = S_DATA;
               else if (tmo_cnt <= 24'd1)    state_next = S_IDLE;
            end
         S_DATA:
            if (sd_clk_en && sym_cnt == 5'd0 && last_word) state_next = S_CRC;
         S_CRC:
            if (sd_clk_en && crc_cnt == 4'd0) state_next = S_END;
         S_END:
            if (sd_clk_en) state_next = S_COMMIT;
         S_COMMIT:
            if (buf_wvalid) state_next = last_block ? S_IDLE : S_WAIT_BUF;
         default:
            state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         crc_err     <= 1'b0;
         buf_we      <= 1'b0;
         buf_wupdate <= 1'b0;
         buf_waddr   <= '0;
         buf_wdata   <= '0;
         buf_wprop   <= '0;
         mode4       <= 1'b0;
         blocks_left <= '0;
         blk_idx     <= '0;
         tmo_cnt     <= '0;
         sym_cnt     <= '0;
         word_idx    <= '0;
         sr          <= '0;
         crc_cnt     <= '0;
         end_err     <= 1'b0;
`ifdef SD_RX_CRC_CHECK_EN
         for (int i = 0; i < 4; i++) begin
            crc_gen[i] <= '0;
            crc_rx[i]  <= '0;
         end
`endif
      end else begin
         buf_we      <= 1'b0;
         buf_wupdate <= 1'b0;
         done        <= 1'b0;
         // busy falls the cycle after done so a coincident start is still ignored
         if (done) busy <= 1'b0;
         if (abort) begin
            busy <= 1'b0;
         end else begin
            case (state)
               S_IDLE:
                  if (start && !busy) begin
                     mode4       <= bus_width_4;
                     blocks_left <= block_count;
                     blk_idx     <= '0;
                     timeout_err <= 1'b0;
                     crc_err     <= 1'b0;
                     busy        <= 1'b1;
                     if (block_count == 16'd0) done <= 1'b1;
                  end
               S_WAIT_BUF: begin
                  tmo_cnt  <= timeout_cycles;
                  sym_cnt  <= sym_reload;
                  word_idx <= '0;
                  crc_cnt  <= 4'd15;
`ifdef SD_RX_CRC_CHECK_EN
                  for (int i = 0; i < 4; i++) crc_gen[i] <= '0;
`endif
               end
               S_WAIT_START:
                  if (sd_clk_en && !start_bit) begin
                     if (tmo_cnt <= 24'd1) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                     end else begin
                        tmo_cnt <= tmo_cnt - 24'd1;
                     end
                  end
               S_DATA:
                  if (sd_clk_en) begin
                     sr <= sr_next;
`ifdef SD_RX_CRC_CHECK_EN
                     for (int i = 0; i < 4; i++) begin
                        if (mode4 || i == 0) crc_gen[i] <= crc_step(crc_gen[i], sd_dat[i]);
                     end
`endif
                     if (sym_cnt == 5'd0) begin
                        buf_we    <= 1'b1;
                        buf_waddr <= word_idx;
                        buf_wdata <= swap_bytes(sr_next);
                        word_idx  <= word_idx + 1'b1;
                        sym_cnt   <= sym_reload;
                     end else begin
                        sym_cnt <= sym_cnt - 5'd1;
                     end
                  end
               S_CRC:
                  if (sd_clk_en) begin
`ifdef SD_RX_CRC_CHECK_EN
                     for (int i = 0; i < 4; i++) crc_rx[i] <= {crc_rx[i][14:0], sd_dat[i]};
`endif
                     crc_cnt <= crc_cnt - 4'd1;
                  end
               S_END:
                  if (sd_clk_en) end_err <= end_bad;
               S_COMMIT:
                  if (buf_wvalid) begin
                     buf_wupdate <= 1'b1;
                     buf_wprop   <= prop;
                     if (crc_bad || end_err) crc_err <= 1'b1;
                     blk_idx <= blk_idx + 16'd1;
                     if (last_block) done <= 1'b1;
                     else            blocks_left <= blocks_left - 16'd1;
                  end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_controller_data_receiver.sv
// Bench for sd_controller_data_receiver: an SD card symbol stream, a write/update scoreboard,
// a table of transfer cases and hand-written hold, abort and zero-count sequences.
module tb_sd_controller_data_receiver;

`ifdef SD_RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic        aclk, aresetn, sd_clk_en, bus_width_4, start, abort, buf_wvalid;
   logic [3:0]  sd_dat;
   logic [15:0] block_count;
   logic [23:0] timeout_cycles;
   logic        busy, done, timeout_err, crc_err, clk_hold, buf_we, buf_wupdate;
   logic [6:0]  buf_waddr;
   logic [31:0] buf_wdata, buf_wprop;

   sd_controller_data_receiver dut (
      .aclk(aclk), .aresetn(aresetn), .sd_clk_en(sd_clk_en), .sd_dat(sd_dat),
      .bus_width_4(bus_width_4), .start(start), .block_count(block_count),
      .timeout_cycles(timeout_cycles), .abort(abort), .busy(busy), .done(done),
      .timeout_err(timeout_err), .crc_err(crc_err), .clk_hold(clk_hold),
      .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_we(buf_we),
      .buf_wprop(buf_wprop), .buf_wupdate(buf_wupdate), .buf_wvalid(buf_wvalid)
   );

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      bit          mode4;
      int          nblk;
      int          pat;
      bit          corrupt;
      int          end_line;
      int          end_blk;
      logic [23:0] tmo;
      bit          exp_tmo;
      bit          exp_crc;
   } vec_t;

   logic [3:0]  card_q [$];
   wr_t         exp_wr [$];
   logic [31:0] exp_up [$];

   int n_checks = 0, n_pass = 0;
   int n_wr = 0, n_up = 0, n_done = 0, hold_cnt = 0, hold_inv = 0, ws_cnt = 0;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
   endtask

   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
      logic [15:0] s;
      s = {c[14:0], 1'b0};
      if (c[15] ^ d) s = s ^ 16'h1021;
      return s;
   endfunction

   // SD clock strobe every other cycle, stopped while the DUT holds the clock
   initial begin
      bit phase;
      phase = 1'b0;
      sd_clk_en = 1'b0;
      sd_dat = 4'hF;
      forever begin
         @(posedge aclk);
         #1;
         phase = ~phase;
         if (phase && !clk_hold && aresetn) begin
            sd_clk_en = 1'b1;
            sd_dat = (card_q.size() > 0) ? card_q.pop_front() : 4'hF;
         end else begin
            sd_clk_en = 1'b0;
         end
      end
   end

   initial begin
      wr_t e;
      logic [31:0] ep;
      forever begin
         @(negedge aclk);
         if (buf_we) begin
            n_wr++;
            if (exp_wr.size() == 0) chk("unexpected_we", 1, 0);
            else begin
               e = exp_wr.pop_front();
               chk("wr_addr", buf_waddr, e.addr);
               chk("wr_data", buf_wdata, e.data);
            end
         end
         if (buf_wupdate) begin
            n_up++;
            if (exp_up.size() == 0) chk("unexpected_wupdate", 1, 0);
            else begin
               ep = exp_up.pop_front();
               chk("wprop", buf_wprop, ep);
            end
         end
         if (buf_we || buf_wupdate) begin
            chk("write_needs_wvalid", buf_wvalid, 1);
            chk("we_with_wupdate", buf_we & buf_wupdate, 0);
         end
         if (done) n_done++;
         if (clk_hold) hold_cnt++;
         if (clk_hold && !buf_wvalid) hold_inv++;
         if (busy && !clk_hold && !done && sd_clk_en) ws_cnt++;
      end
   end

   task automatic push_block(input bit m4, input int pat, input int b, input bit corrupt,
                             input bit end_low, input int end_line);
      logic [15:0] crc [4];
      logic [7:0]  by;
      logic [3:0]  sym;
      logic [31:0] w;
      bit crcbad, endbad;
      for (int i = 0; i < 4; i++) crc[i] = '0;
      w = '0;
      repeat (4) card_q.push_back(4'hF);
      card_q.push_back(m4 ? 4'h0 : 4'hE);
      for (int n = 0; n < 512; n++) begin
         by = (pat == 1) ? 8'h5A : 8'((n + 7 * b) & 255);
         w[8*(n%4) +: 8] = by;
         if (n % 4 == 3) exp_wr.push_back('{addr: 7'(n / 4), data: w});
         if (m4) begin
            for (int h = 1; h >= 0; h--) begin
               sym = (h == 1) ? by[7:4] : by[3:0];
               for (int i = 0; i < 4; i++) crc[i] = crc_step(crc[i], sym[i]);
               card_q.push_back(sym);
            end
         end else begin
            for (int k = 7; k >= 0; k--) begin
               crc[0] = crc_step(crc[0], by[k]);
               card_q.push_back({3'b111, by[k]});
            end
         end
      end
      for (int k = 15; k >= 0; k--) begin
         if (m4) for (int i = 0; i < 4; i++) sym[i] = crc[i][k];
         else    sym = {3'b111, crc[0][k]};
         if (corrupt && k == 15) sym[0] = ~sym[0];
         card_q.push_back(sym);
      end
      sym = 4'hF;
      if (end_low) sym[end_line] = 1'b0;
      card_q.push_back(sym);
      endbad = end_low && (m4 || end_line == 0);
      crcbad = corrupt && CRC_EN;
      exp_up.push_back(32'(b) | (32'(crcbad) << 16) | (32'(endbad) << 17));
   endtask

   task automatic run_case(input vec_t v);
      int d0;
      bus_width_4 = v.mode4;
      block_count = 16'(v.nblk);
      timeout_cycles = v.tmo;
      if (!v.exp_tmo)
         for (int b = 0; b < v.nblk; b++)
            push_block(v.mode4, v.pat, b, v.corrupt, (v.end_line >= 0) && (b == v.end_blk),
                       (v.end_line < 0) ? 0 : v.end_line);
      d0 = n_done;
      ws_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20000 && n_done == d0; i++) step();
      chk("done_pulses", n_done - d0, 1);
      chk("timeout_err", timeout_err, v.exp_tmo);
      chk("crc_err", crc_err, v.exp_crc);
      if (v.exp_tmo) chk("timeout_strobes", ws_cnt, v.tmo);
      repeat (3) step();
      chk("busy_after_done", busy, 0);
      chk("writes_left", exp_wr.size(), 0);
      chk("updates_left", exp_up.size(), 0);
      card_q.delete();
      exp_wr.delete();
      exp_up.delete();
   endtask

   initial begin
      vec_t vecs [4];
      int d0, u0, w0;
      vecs[0] = '{1'b1, 1, 0, 1'b0, -1, 0, 24'd1000, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1, 1, 1'b1, -1, 0, 24'd1000, 1'b0, CRC_EN};
      vecs[2] = '{1'b1, 2, 0, 1'b0,  2, 0, 24'd1000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1, 0, 1'b0, -1, 0, 24'd10,   1'b1, 1'b0};

      aresetn = 1'b0; start = 1'b0; abort = 1'b0; buf_wvalid = 1'b1;
      bus_width_4 = 1'b1; block_count = '0; timeout_cycles = 24'd1000;
      repeat (4) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_crc_err", crc_err, 0);
      chk("rst_clk_hold", clk_hold, 0);
      chk("rst_we", buf_we, 0);
      chk("rst_wupdate", buf_wupdate, 0);
      chk("rst_waddr", buf_waddr, 0);
      chk("rst_wdata", buf_wdata, 0);
      chk("rst_wprop", buf_wprop, 0);
      aresetn = 1'b1;
      repeat (2) step();

      // zero blocks: done on the cycle after start, no buffer activity
      w0 = n_wr;
      block_count = 16'd0;
      start = 1'b1;
      @(negedge aclk);
      chk("zero_count_done", done, 1);
      #1 start = 1'b0;
      repeat (4) step();
      chk("zero_count_busy", busy, 0);
      chk("zero_count_writes", n_wr - w0, 0);

      for (int c = 0; c < 4; c++) run_case(vecs[c]);

      // three blocks, write half withheld for 200 cycles before block 1
      bus_width_4 = 1'b1;
      block_count = 16'd3;
      timeout_cycles = 24'd1000;
      for (int b = 0; b < 3; b++) push_block(1'b1, 0, b, 1'b0, 1'b0, 0);
      d0 = n_done;
      hold_cnt = 0;
      hold_inv = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      begin
         int i;
         for (i = 0; i < 20000; i++) begin
            @(negedge aclk);
            if (buf_wupdate) break;
         end
         #1;
         chk("first_wupdate_seen", i < 20000, 1);
      end
      buf_wvalid = 1'b0;
      repeat (200) @(negedge aclk);
      #1 buf_wvalid = 1'b1;
      for (int i = 0; i < 20000 && n_done == d0; i++) step();
      chk("hold_done", n_done - d0, 1);
      chk("hold_total_cycles", hold_cnt, 203);
      chk("hold_while_invalid", hold_inv, 200);
      chk("hold_crc_err", crc_err, 0);
      chk("hold_writes_left", exp_wr.size(), 0);
      chk("hold_updates_left", exp_up.size(), 0);
      repeat (3) step();
      card_q.delete();

      // abort in the middle of DATA at word 40, then a clean block
      block_count = 16'd1;
      push_block(1'b1, 1, 0, 1'b0, 1'b0, 0);
      w0 = n_wr;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20000 && (n_wr - w0) < 40; i++) step();
      chk("abort_words_before", n_wr - w0, 40);
      d0 = n_done;
      u0 = n_up;
      abort = 1'b1;
      card_q.delete();
      exp_wr.delete();
      exp_up.delete();
      step();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_clk_hold", clk_hold, 0);
      repeat (40) step();
      chk("abort_no_done", n_done - d0, 0);
      chk("abort_no_wupdate", n_up - u0, 0);
      chk("abort_no_more_writes", n_wr - w0, 40);
      run_case(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
